branch_resolve_queue: RTL and testbench

Tracks every conditional branch between fetch-time prediction and execute-time resolution in the LC-3b pipeline. It is a FIFO of in-flight predictions. Fetch pushes the branch PC, the predicted direction from the branch predictor, and the predicted target. Execute pops and resolves the oldest entry. The block returns registered training pulses to the branch predictor (address, branch strobe, taken/not-taken) and registered mispredict/redirect signals to fetch.

---
 rtl/branch_resolve_queue.sv | 97 +++++++++
 tb/tb_branch_resolve_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-flight conditional branch tracker: a FIFO of fetch-time predictions, resolved
// oldest-first by execute, producing registered predictor training and fetch redirects.
module branch_resolve_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  input  logic [15:0]                  push_pc,
  input  logic                         push_pred,
  input  logic [15:0]                  push_target,
  output logic                         push_ready,
  input  logic                         res_valid,
  input  logic                         res_taken,
  input  logic [15:0]                  res_target,
  output logic [15:0]                  upd_address,
  output logic                         upd_br,
  output logic                         upd_taken,
  output logic                         upd_not_taken,
  output logic                         mispredict,
  output logic [15:0]                  redirect_pc,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [15:0]      pc_mem  [DEPTH];
  logic [15:0]      tgt_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic        do_res;
  logic        do_push;
  logic        dir_miss;
  logic        tgt_miss;
  logic        mispredict_next;
  logic [15:0] redirect_next;

  assign push_ready      = (count < CW'(DEPTH));
  assign do_res          = res_valid && (count != '0);
  assign dir_miss        = (res_taken != pred_mem[head]);
  assign tgt_miss        = res_taken && pred_mem[head] && (res_target != tgt_mem[head]);
  assign mispredict_next = do_res && (dir_miss || tgt_miss);
  // A push racing a mispredict (or arriving while one is visible) is wrong-path.
  assign do_push         = push_valid && push_ready && !mispredict && !mispredict_next;
  assign redirect_next   = res_taken ? res_target : (pc_mem[head] + 16'd2);

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[tail]   <= push_pc;
      pred_mem[tail] <= push_pred;
      tgt_mem[tail]  <= push_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      upd_address   <= 16'h0000;
      upd_br        <= 1'b0;
      upd_taken     <= 1'b0;
      upd_not_taken <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= 16'h0000;
      underflow     <= 1'b0;
    end else begin
      upd_br        <= do_res;
      upd_taken     <= do_res && res_taken;
      upd_not_taken <= do_res && !res_taken;
      mispredict    <= mispredict_next;
      underflow     <= res_valid && (count == '0);
      if (do_res) begin
        upd_address <= pc_mem[head];
        redirect_pc <= redirect_next;
      end
      if (mispredict_next) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_res)  head <= head + PW'(1);
        if (do_push) tail <= tail + PW'(1);
        case ({do_push, do_res})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH = 4).
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid = 1'b0;
  logic [15:0] push_pc = '0;
  logic        push_pred = 1'b0;
  logic [15:0] push_target = '0;
  logic        push_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [15:0] res_target = '0;
  logic [15:0] upd_address;
  logic        upd_br;
  logic        upd_taken;
  logic        upd_not_taken;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        underflow;
  logic [2:0]  count;

  int n_pass = 0;
  int n_total = 0;

  branch_resolve_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred),
    .push_target(push_target), .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_address(upd_address), .upd_br(upd_br), .upd_taken(upd_taken),
    .upd_not_taken(upd_not_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, step past the edge, then return inputs to idle.
  task automatic cyc(input logic pv, input logic [15:0] ppc, input logic ppred,
                     input logic [15:0] ptgt, input logic rv, input logic rt,
                     input logic [15:0] rtgt);
    push_valid = pv; push_pc = ppc; push_pred = ppred; push_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    @(posedge clk); #1;
    push_valid = 1'b0; push_pc = '0; push_pred = 1'b0; push_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
  endtask

  task automatic test_reset();
    logic seen_br;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    n_total++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
    n_total++; if (push_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", push_ready); else n_pass++;
    n_total++; if ({upd_br, upd_taken, upd_not_taken, mispredict, underflow} !== 5'b0)
      $display("FAIL rst_pulses got %b want 00000", {upd_br, upd_taken, upd_not_taken, mispredict, underflow}); else n_pass++;
    n_total++; if ({upd_address, redirect_pc} !== 32'h0)
      $display("FAIL rst_addrs got %h want 00000000", {upd_address, redirect_pc}); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1, 16'h3000, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 16'h3002, 1, 16'h3100, 0, 0, 16'h0);
    cyc(1, 16'h3004, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (count !== 3'd3) $display("FAIL mid_fill got %0d want 3", count); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (count !== 3'd0) $display("FAIL mid_rst_count got %0d want 0", count); else n_pass++;
    n_total++; if (push_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", push_ready); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    seen_br = 1'b0;
    cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    seen_br |= upd_br;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      seen_br |= upd_br;
    end
    n_total++; if (seen_br !== 1'b0) $display("FAIL mid_rst_no_train got %b want 0", seen_br); else n_pass++;
  endtask

  task automatic test_correct();
    cyc(1, 16'h3000, 1, 16'h3010, 0, 0, 16'h0);
    cyc(1, 16'h3004, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (count !== 3'd2) $display("FAIL corr_fill got %0d want 2", count); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 1, 1, 16'h3010);
    n_total++; if ({upd_br, upd_taken, upd_not_taken, mispredict} !== 4'b1100)
      $display("FAIL corr_r1_flags got %b want 1100", {upd_br, upd_taken, upd_not_taken, mispredict}); else n_pass++;
    n_total++; if (upd_address !== 16'h3000) $display("FAIL corr_r1_addr got %h want 3000", upd_address); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL corr_r1_count got %0d want 1", count); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    n_total++; if ({upd_br, upd_taken, upd_not_taken, mispredict} !== 4'b1010)
      $display("FAIL corr_r2_flags got %b want 1010", {upd_br, upd_taken, upd_not_taken, mispredict}); else n_pass++;
    n_total++; if (upd_address !== 16'h3004) $display("FAIL corr_r2_addr got %h want 3004", upd_address); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL corr_r2_count got %0d want 0", count); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (upd_br !== 1'b0) $display("FAIL corr_strobe_one_cycle got %b want 0", upd_br); else n_pass++;
  endtask

  task automatic test_dir_mispredict();
    cyc(1, 16'h3020, 0, 16'h3024, 0, 0, 16'h0);
    cyc(1, 16'h3030, 1, 16'h3040, 0, 0, 16'h0);
    cyc(1, 16'h3034, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 16'h3050, 0, 16'h0, 1, 1, 16'h3100);
    n_total++; if (mispredict !== 1'b1) $display("FAIL dir_mp got %b want 1", mispredict); else n_pass++;
    n_total++; if (redirect_pc !== 16'h3100) $display("FAIL dir_redirect got %h want 3100", redirect_pc); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL dir_flush_count got %0d want 0", count); else n_pass++;
    n_total++; if ({upd_br, upd_taken, upd_address} !== {2'b11, 16'h3020})
      $display("FAIL dir_train got %b%b/%h want 11/3020", upd_br, upd_taken, upd_address); else n_pass++;
    cyc(1, 16'h3060, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if ({mispredict, count} !== 4'b0000)
      $display("FAIL dir_push_during_mp got mp=%b count=%0d want mp=0 count=0", mispredict, count); else n_pass++;
    cyc(1, 16'h3070, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (count !== 3'd1) $display("FAIL dir_push_n2 got %0d want 1", count); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    n_total++; if ({upd_address, mispredict, count} !== {16'h3070, 1'b0, 3'd0})
      $display("FAIL dir_after got addr=%h mp=%b count=%0d want 3070/0/0", upd_address, mispredict, count); else n_pass++;
  endtask

  task automatic test_target();
    cyc(1, 16'h3200, 1, 16'h4000, 0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 1, 16'h4002);
    n_total++; if ({mispredict, redirect_pc} !== {1'b1, 16'h4002})
      $display("FAIL tgt_mp got mp=%b pc=%h want 1/4002", mispredict, redirect_pc); else n_pass++;
    n_total++; if (upd_taken !== 1'b1) $display("FAIL tgt_taken got %b want 1", upd_taken); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (mispredict !== 1'b0) $display("FAIL tgt_mp_pulse got %b want 0", mispredict); else n_pass++;
    cyc(1, 16'hFFFE, 1, 16'h1234, 0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    n_total++; if ({mispredict, redirect_pc} !== {1'b1, 16'h0000})
      $display("FAIL wrap_redirect got mp=%b pc=%h want 1/0000", mispredict, redirect_pc); else n_pass++;
    n_total++; if ({upd_not_taken, upd_address} !== {1'b1, 16'hFFFE})
      $display("FAIL wrap_train got nt=%b addr=%h want 1/fffe", upd_not_taken, upd_address); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic test_full_wrap();
    logic [15:0] q[$];
    logic [15:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'h5000 + 16'(2*i), 0, 16'h0, 0, 0, 16'h0);
      q.push_back(16'h5000 + 16'(2*i));
    end
    n_total++; if ({count, push_ready} !== {3'd4, 1'b0})
      $display("FAIL full_state got count=%0d ready=%b want 4/0", count, push_ready); else n_pass++;
    cyc(1, 16'h5100, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (count !== 3'd4) $display("FAIL full_drop got %0d want 4", count); else n_pass++;
    cyc(1, 16'h5200, 0, 16'h0, 1, 0, 16'h0);
    exp_pc = q.pop_front();
    n_total++; if ({upd_address, count} !== {exp_pc, 3'd3})
      $display("FAIL full_push_pop got addr=%h count=%0d want %h/3", upd_address, count, exp_pc); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        cyc(1, 16'h6000 + 16'(2*i), 0, 16'h0, 0, 0, 16'h0);
        q.push_back(16'h6000 + 16'(2*i));
        n_total++; if (count !== 3'd4) $display("FAIL alt_push_%0d got %0d want 4", i, count); else n_pass++;
      end else begin
        cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
        exp_pc = q.pop_front();
        n_total++; if ({upd_br, upd_address, count} !== {1'b1, exp_pc, 3'd3})
          $display("FAIL alt_pop_%0d got br=%b addr=%h count=%0d want 1/%h/3", i, upd_br, upd_address, count, exp_pc); else n_pass++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
      exp_pc = q.pop_front();
      n_total++; if ({upd_br, upd_address} !== {1'b1, exp_pc})
        $display("FAIL b2b_pop_%0d got br=%b addr=%h want 1/%h", i, upd_br, upd_address, exp_pc); else n_pass++;
    end
    n_total++; if (count !== 3'd0) $display("FAIL drain_count got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_underflow();
    cyc(0, 16'h0, 0, 16'h0, 1, 1, 16'h7000);
    n_total++; if ({underflow, upd_br, mispredict, count} !== {3'b100, 3'd0})
      $display("FAIL uf got uf=%b br=%b mp=%b count=%0d want 1/0/0/0", underflow, upd_br, mispredict, count); else n_pass++;
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    n_total++; if (underflow !== 1'b0) $display("FAIL uf_pulse got %b want 0", underflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_target();
    test_full_wrap();
    test_underflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
